ibex_pmp_check_arbiter: RTL and testbench

- Shares one ibex_pmp access-checking channel between NumReq requesters, for example the debug module, a DMA engine and the LSU side-port.
- Arbitrates round-robin and drives a registered address, type and privilege onto the PMP channel.
- Captures the combinational PMP error and returns it to the winning requester through a valid/ready response handshake.
- Sits between the requesters and one pmp_req_addr_i/pmp_req_type_i/priv_mode_i/pmp_req_err_o slot of ibex_pmp.

---
 rtl/ibex_pmp_check_arbiter.sv | 101 ++++++++++
 tb/tb_ibex_pmp_check_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmp_check_arbiter.sv
// Round-robin arbiter sharing one ibex_pmp check channel between NumReq requesters.
// The winner's request is registered onto the channel, and the PMP verdict is returned over a valid/ready response.
module ibex_pmp_check_arbiter #(
  parameter int NumReq = 3,
  localparam int PtrW = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][33:0]  req_addr_i,
  input  logic [NumReq-1:0][1:0]   req_type_i,
  input  logic [NumReq-1:0][1:0]   req_priv_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic                     rsp_err_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic [33:0]              pmp_addr_o,
  output logic [1:0]               pmp_type_o,
  output logic [1:0]               pmp_priv_o,
  input  logic                     pmp_err_i,
  input  logic                     pmp_cfg_wr_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   winner_q;
  logic              gnt_found;
  logic [PtrW-1:0]   gnt_idx;
  logic [PtrW-1:0]   cand;

  // Scan from rr_ptr upward with wrap; the first pending requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NumReq);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_ready_o = '0;
    if (state_q == IDLE && gnt_found && !rst_i) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      pmp_addr_o  <= '0;
      pmp_type_o  <= 2'b00;
      pmp_priv_o  <= 2'b11;
      busy_o      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_found) begin
            pmp_addr_o <= req_addr_i[gnt_idx];
            pmp_type_o <= req_type_i[gnt_idx];
            pmp_priv_o <= req_priv_i[gnt_idx];
            winner_q   <= gnt_idx;
            busy_o     <= 1'b1;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          // A concurrent config write may invalidate this cycle's verdict: recheck.
          if (!pmp_cfg_wr_i) begin
            rsp_err_o   <= pmp_err_i;
            rsp_valid_o <= NumReq'(1) << winner_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i[winner_q]) begin
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            rr_ptr_q    <= (winner_q == PtrW'(NumReq - 1)) ? '0 : winner_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_pmp_check_arbiter.sv
// Directed bench for ibex_pmp_check_arbiter: vector table plus multi-cycle corner sequences.
module tb_ibex_pmp_check_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0]       req_valid_i;
  logic [2:0]       req_ready_o;
  logic [2:0][33:0] req_addr_i;
  logic [2:0][1:0]  req_type_i;
  logic [2:0][1:0]  req_priv_i;
  logic [2:0]       rsp_valid_o;
  logic             rsp_err_o;
  logic [2:0]       rsp_ready_i;
  logic [33:0]      pmp_addr_o;
  logic [1:0]       pmp_type_o;
  logic [1:0]       pmp_priv_o;
  logic             pmp_err_i;
  logic             pmp_cfg_wr_i;
  logic             busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  ibex_pmp_check_arbiter #(.NumReq(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_type_i   (req_type_i),
    .req_priv_i   (req_priv_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_ready_i  (rsp_ready_i),
    .pmp_addr_o   (pmp_addr_o),
    .pmp_type_o   (pmp_type_o),
    .pmp_priv_o   (pmp_priv_o),
    .pmp_err_i    (pmp_err_i),
    .pmp_cfg_wr_i (pmp_cfg_wr_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]       valid;
    logic [2:0][33:0] addr;
    logic [2:0][1:0]  typ;
    logic [2:0][1:0]  priv;
    logic             err;
    int unsigned      win;
  } vec_t;

  vec_t tbl[6];

  // Starts and ends on a falling edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    logic [2:0] oh;
    oh = 3'b001 << v.win;
    req_valid_i = v.valid;
    req_addr_i  = v.addr;
    req_type_i  = v.typ;
    req_priv_i  = v.priv;
    #1;
    chk("vec_ready", 64'(req_ready_o), 64'(oh));
    @(negedge clk_i);
    chk("vec_addr", 64'(pmp_addr_o), 64'(v.addr[v.win]));
    chk("vec_type", 64'(pmp_type_o), 64'(v.typ[v.win]));
    chk("vec_priv", 64'(pmp_priv_o), 64'(v.priv[v.win]));
    chk("vec_busy_check", 64'(busy_o), 64'd1);
    chk("vec_no_rsp_in_check", 64'(rsp_valid_o), 64'd0);
    chk("vec_no_ready_in_check", 64'(req_ready_o), 64'd0);
    req_valid_i = '0;
    pmp_err_i   = v.err;
    @(negedge clk_i);
    chk("vec_rsp_valid", 64'(rsp_valid_o), 64'(oh));
    chk("vec_rsp_err", 64'(rsp_err_o), 64'(v.err));
    rsp_ready_i = 3'b111;
    pmp_err_i   = 1'b0;
    @(negedge clk_i);
    chk("vec_idle_rsp", 64'(rsp_valid_o), 64'd0);
    chk("vec_idle_busy", 64'(busy_o), 64'd0);
    chk("vec_idle_addr_hold", 64'(pmp_addr_o), 64'(v.addr[v.win]));
    rsp_ready_i = '0;
  endtask

  initial begin
    logic [2:0] g_rdy[6];
    int         g_cyc[6];
    int         ng;

    // EXEC=00, WRITE=01, READ=10; priv U=00, S=01, M=11.  rr_ptr evolves 0->1->2->1->0->2->0.
    tbl[0] = '{3'b001, {34'h0, 34'h0, 34'h0_0000_1000}, {2'b00, 2'b00, 2'b10}, {2'b00, 2'b00, 2'b00}, 1'b0, 0};
    tbl[1] = '{3'b011, {34'h0, 34'h2_0000_0004, 34'h0_0000_0040}, {2'b00, 2'b00, 2'b01}, {2'b00, 2'b11, 2'b01}, 1'b1, 1};
    tbl[2] = '{3'b011, {34'h0, 34'h1_2345_6788, 34'h0_ABCD_0000}, {2'b00, 2'b10, 2'b01}, {2'b00, 2'b00, 2'b11}, 1'b0, 0};
    tbl[3] = '{3'b100, {34'h3_FFFF_FFFC, 34'h0, 34'h0}, {2'b11, 2'b00, 2'b00}, {2'b01, 2'b00, 2'b00}, 1'b1, 2};
    tbl[4] = '{3'b110, {34'h0_0000_0100, 34'h2_AAAA_5554, 34'h0}, {2'b10, 2'b01, 2'b00}, {2'b00, 2'b11, 2'b00}, 1'b0, 1};
    tbl[5] = '{3'b111, {34'h1_0000_0000, 34'h0_DEAD_BEEC, 34'h0_0000_0008}, {2'b01, 2'b10, 2'b00}, {2'b11, 2'b00, 2'b01}, 1'b1, 2};

    rst_i        = 1'b1;
    req_valid_i  = 3'b111;
    req_addr_i   = '0;
    req_type_i   = '0;
    req_priv_i   = '0;
    rsp_ready_i  = '0;
    pmp_err_i    = 1'b0;
    pmp_cfg_wr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("rst_addr", 64'(pmp_addr_o), 64'd0);
    chk("rst_type", 64'(pmp_type_o), 64'd0);
    chk("rst_priv", 64'(pmp_priv_o), 64'd3);
    chk("rst_busy", 64'(busy_o), 64'd0);
    req_valid_i = '0;
    rst_i       = 1'b0;
    @(negedge clk_i);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Round-robin: everyone valid, responses always accepted.
    req_valid_i = 3'b111;
    rsp_ready_i = 3'b111;
    ng = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (|req_ready_o) begin
        g_rdy[ng] = req_ready_o;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (ng == 6) break;
      @(negedge clk_i);
    end
    chk("rr_grant_count", 64'(ng), 64'd6);
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", 64'(g_rdy[k]), 64'(3'b001 << (k % 3)));
      if (k > 0) chk("rr_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'd3);
    end
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rr_idle", 64'(busy_o), 64'd0);
    rsp_ready_i = '0;

    // Config write held two cycles in CHECK; rr_ptr is 0 here.
    req_valid_i   = 3'b001;
    req_addr_i[0] = 34'h0_0000_2000;
    #1;
    chk("cfg_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i  = '0;
    pmp_cfg_wr_i = 1'b1;
    pmp_err_i    = 1'b0;
    @(negedge clk_i);
    chk("cfg_still_check1", 64'(rsp_valid_o), 64'd0);
    chk("cfg_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    chk("cfg_still_check2", 64'(rsp_valid_o), 64'd0);
    pmp_cfg_wr_i = 1'b0;
    pmp_err_i    = 1'b1;
    @(negedge clk_i);
    chk("cfg_rsp_valid_t4", 64'(rsp_valid_o), 64'd1);
    chk("cfg_rsp_err", 64'(rsp_err_o), 64'd1);
    pmp_cfg_wr_i = 1'b1;
    pmp_err_i    = 1'b0;
    @(negedge clk_i);
    chk("cfg_in_resp_ignored_valid", 64'(rsp_valid_o), 64'd1);
    chk("cfg_in_resp_ignored_err", 64'(rsp_err_o), 64'd1);
    pmp_cfg_wr_i = 1'b0;
    rsp_ready_i  = 3'b001;
    @(negedge clk_i);
    chk("cfg_done", 64'(rsp_valid_o), 64'd0);
    rsp_ready_i = '0;

    // Backpressure on requester 2 while requester 0 waits; rr_ptr is 1.
    req_valid_i   = 3'b101;
    req_addr_i[2] = 34'h1_0000_0040;
    #1;
    chk("bp_ready2", 64'(req_ready_o), 64'd4);
    @(negedge clk_i);
    req_valid_i = 3'b001;
    pmp_err_i   = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 3'b011;
    pmp_err_i   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", 64'(rsp_valid_o), 64'd4);
      chk("bp_hold_err", 64'(rsp_err_o), 64'd1);
      chk("bp_no_grant", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
    end
    rsp_ready_i = 3'b100;
    @(negedge clk_i);
    rsp_ready_i = '0;
    #1;
    chk("bp_req0_next", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    chk("bp_req0_rsp", 64'(rsp_valid_o), 64'd1);
    chk("bp_req0_err", 64'(rsp_err_o), 64'd0);
    rsp_ready_i = 3'b001;
    @(negedge clk_i);
    rsp_ready_i = '0;

    // Asynchronous reset while in CHECK; rr_ptr is 1.
    req_valid_i   = 3'b010;
    req_addr_i[1] = 34'h2_0000_0800;
    req_priv_i[1] = 2'b01;
    @(negedge clk_i);
    req_valid_i = '0;
    chk("ar_in_check", 64'(busy_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_addr", 64'(pmp_addr_o), 64'd0);
    chk("ar_priv", 64'(pmp_priv_o), 64'd3);
    chk("ar_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("ar_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
    req_valid_i = 3'b111;
    #1;
    chk("ar_grant_from_0", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (2) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
